forwarding_hazard_unit: RTL and testbench
=========================================

# forwarding_hazard_unit

Generates the operand-forwarding selects consumed by the execute stage (ALU_src1, ALU_src2, Store_Value_sel) and the load-use stall for the decode stage of the 5-stage MIPS pipeline. It tracks the destination register, write-enable and load flag of the instructions in EXE and MEM internally. It compares the decoding instruction's source registers against them and registers the resulting selects into the ID/EXE boundary, so they are valid for the whole cycle the instruction spends in EXE.

## Interface
- REG_ADDR_LEN, 5, register-file address width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- freeze  input  1  global pipeline hold; all internal state and outputs hold
- flush  input  1  branch flush; instruction in ID is squashed into a bubble
- fwd_en  input  1  0 = forwarding disabled (all selects 0, stall on any RAW hazard)
- id_src1, id_src2  input  REG_ADDR_LEN  source registers of the instruction in ID
- id_use_src1, id_use_src2  input  1  instruction actually reads src1 / src2
- id_is_imm  input  1  ALU operand 2 is an immediate (src2 not used by ALU)
- id_is_store  input  1  instruction is a store; src2 supplies store data
- id_dest  input  REG_ADDR_LEN  destination register
- id_wb_en  input  1  instruction writes the register file
- id_mem_read  input  1  instruction is a load
- ALU_src1, ALU_src2, Store_Value_sel  output  2  forwarding selects to EXE: 0 register value, 1 ALU_Result_MEM, 2 Result_WB; 3 never driven
- stall  output  1  hold PC and IF/ID; combinational

## Operation
- Tracking registers: exe_{dest,wb,load} = instruction now in EXE; mem_{dest,wb} = instruction now in MEM.
- Hazard match of source s against stage X: id_use_s && X_wb && X_dest == s && s != 0.
- Select for source s (fwd_en=1): match vs exe -> 1 (that instruction will be in MEM next cycle); else match vs mem -> 2; else 0. A younger (exe) match always wins over an older (mem) match.
- ALU_src2 is computed from id_src2 only when !id_is_imm; otherwise 0.
- Store_Value_sel is computed from id_src2 only when id_is_store; otherwise 0.
- stall (fwd_en=1): exe_load && (match(src1) || match(src2) vs exe). A store using src2 as data counts as a src2 use.
- stall (fwd_en=0): any match vs exe or mem on either used source.
- stall is forced to 0 when flush=1 or freeze=1.
- Update each rising edge when !freeze:
  - mem_* <= exe_*.
  - If stall || flush: exe_wb, exe_load <= 0 (bubble), and all three selects <= 0.
  - Else exe_* <= id_* and selects <= computed values.
- Register 0 is never forwarded and never causes a stall.

## Timing
- Reset (rst=1 at an edge) clears all tracking registers, ALU_src1, ALU_src2 and Store_Value_sel to 0. stall is 0 while the tracking state is zero. rst has priority over freeze and flush.
- Selects are registered: they change one edge after the instruction leaves ID and are stable during its EXE cycle.
- Load-use: exactly one stall cycle per hazard. After the bubble, the load is in MEM when the dependent instruction is in ID, so the dependent gets sel=2 in its EXE cycle.
- Simultaneous flush and stall: flush wins; a bubble is inserted and stall=0.
- freeze for N cycles: outputs and state are unchanged for N cycles; stall is deasserted.

## Test plan
- Back-to-back ALU: `add r3,r1,r2` then `sub r4,r3,r5` -> in sub's EXE cycle ALU_src1=1, ALU_src2=0, stall never asserted.
- Distance-2 with a younger match: `add r3`; `or r3`; `and r6,r3,r3` -> ALU_src1=ALU_src2=1 (younger `or` wins). With an unrelated middle instruction -> both selects = 2.
- Load-use: `lw r2,0(r1)` then `add r4,r2,r2` -> stall=1 for exactly one cycle, one bubble (selects 0), then ALU_src1=ALU_src2=2.
- Store data: `add r7,...` then `sw r7,4(r1)` -> Store_Value_sel=1, ALU_src2=0 (immediate).
- r0 and fwd_en=0: writing r0 then reading r0 -> all selects 0, no stall. With fwd_en=0, a distance-1 RAW -> stall for 2 cycles, selects 0.
- flush coincident with a load-use hazard -> stall=0 and a bubble is inserted; rst asserted mid-stall -> next cycle all outputs 0 and stall=0.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// ---------------------------------------------------------------------------
// forwarding_hazard_unit
//
// Operand-forwarding and load-use hazard control for a 5-stage MIPS pipeline.
// The unit keeps its own copy of the destination register, write-enable and
// load flag for the instructions now in EXE (_p1) and MEM (_p2). It compares
// the decoding instruction's sources against them and registers the
// resulting forwarding selects across the ID/EXE boundary. The selects
// therefore hold steady for the whole EXE cycle of the instruction.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   freeze            global hold: state and outputs keep their value,
//                     and stall is held low
//   flush             squash the instruction in ID into a bubble
//   fwd_en            0 disables forwarding: selects stay 0 and the unit
//                     stalls on any RAW hazard
//   id_src1/2         source registers of the instruction in ID
//   id_use_src1/2     the instruction reads src1 / src2
//   id_is_imm         ALU operand 2 is an immediate
//   id_is_store       store instruction; src2 supplies the store data
//   id_dest           destination register
//   id_wb_en          instruction writes the register file
//   id_mem_read       instruction is a load
//   ALU_src1/2        EXE operand select: 0 register, 1 ALU_Result_MEM,
//                     2 Result_WB
//   Store_Value_sel   EXE store-data select, same encoding
//   stall             combinational hold for PC and IF/ID
// ---------------------------------------------------------------------------
module forwarding_hazard_unit #(
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic                    fwd_en,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_use_src1,
  input  logic                    id_use_src2,
  input  logic                    id_is_imm,
  input  logic                    id_is_store,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_mem_read,
  output logic [1:0]              ALU_src1,
  output logic [1:0]              ALU_src2,
  output logic [1:0]              Store_Value_sel,
  output logic                    stall
);

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  // RAW match of one source against one tracked stage. Register 0 is
  // hard-wired to zero, so it never matches.
  function automatic logic raw_hit(
    input logic                    use_src,
    input logic                    stage_wb,
    input logic [REG_ADDR_LEN-1:0] stage_dest,
    input logic [REG_ADDR_LEN-1:0] src
  );
    return use_src && stage_wb && (stage_dest == src) && (src != '0);
  endfunction

  // The EXE producer is younger than the MEM producer, so its value wins.
  function automatic logic [1:0] fwd_sel(
    input logic en,
    input logic hit_exe,
    input logic hit_mem
  );
    logic [1:0] sel;
    sel = SEL_REG;
    if (en) begin
      if (hit_exe)
        sel = SEL_MEM;
      else if (hit_mem)
        sel = SEL_WB;
    end
    return sel;
  endfunction

  // Tracked pipeline state: _p1 = instruction in EXE, _p2 = instruction in MEM
  logic [REG_ADDR_LEN-1:0] dest_p1;
  logic                    wb_p1;
  logic                    load_p1;
  logic [REG_ADDR_LEN-1:0] dest_p2;
  logic                    wb_p2;
  logic [1:0]              alu_src1_p1;
  logic [1:0]              alu_src2_p1;
  logic [1:0]              store_sel_p1;

  // ID-stage (_p0) combinational decisions
  logic       use2_alu_p0;
  logic       use2_any_p0;
  logic       h1_exe_p0;
  logic       h1_mem_p0;
  logic       h2a_exe_p0;
  logic       h2a_mem_p0;
  logic       h2s_exe_p0;
  logic       h2s_mem_p0;
  logic       h2_exe_p0;
  logic       h2_mem_p0;
  logic       stall_raw_p0;
  logic       stall_p0;
  logic       bubble_p0;
  logic [1:0] alu_src1_p0;
  logic [1:0] alu_src2_p0;
  logic [1:0] store_sel_p0;

  // ---- ID stage: hazard detection and select computation ----
  always_comb begin
    use2_alu_p0  = id_use_src2 && !id_is_imm;
    // Store data is a real read of src2 even when the ALU takes an immediate.
    use2_any_p0  = id_use_src2 || id_is_store;

    h1_exe_p0    = raw_hit(id_use_src1, wb_p1, dest_p1, id_src1);
    h1_mem_p0    = raw_hit(id_use_src1, wb_p2, dest_p2, id_src1);
    h2a_exe_p0   = raw_hit(use2_alu_p0, wb_p1, dest_p1, id_src2);
    h2a_mem_p0   = raw_hit(use2_alu_p0, wb_p2, dest_p2, id_src2);
    h2s_exe_p0   = raw_hit(id_is_store, wb_p1, dest_p1, id_src2);
    h2s_mem_p0   = raw_hit(id_is_store, wb_p2, dest_p2, id_src2);
    h2_exe_p0    = raw_hit(use2_any_p0, wb_p1, dest_p1, id_src2);
    h2_mem_p0    = raw_hit(use2_any_p0, wb_p2, dest_p2, id_src2);

    alu_src1_p0  = fwd_sel(fwd_en, h1_exe_p0, h1_mem_p0);
    alu_src2_p0  = fwd_sel(fwd_en, h2a_exe_p0, h2a_mem_p0);
    store_sel_p0 = fwd_sel(fwd_en, h2s_exe_p0, h2s_mem_p0);

    // With forwarding only a load in EXE is too late to forward from;
    // without forwarding every producer still in flight blocks the read.
    if (fwd_en)
      stall_raw_p0 = load_p1 && (h1_exe_p0 || h2_exe_p0);
    else
      stall_raw_p0 = h1_exe_p0 || h1_mem_p0 || h2_exe_p0 || h2_mem_p0;

    stall_p0  = stall_raw_p0 && !flush && !freeze;
    bubble_p0 = stall_p0 || flush;
  end

  // ---- ID/EXE and EXE/MEM boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_p1      <= '0;
      wb_p1        <= 1'b0;
      load_p1      <= 1'b0;
      dest_p2      <= '0;
      wb_p2        <= 1'b0;
      alu_src1_p1  <= SEL_REG;
      alu_src2_p1  <= SEL_REG;
      store_sel_p1 <= SEL_REG;
    end else if (!freeze) begin
      dest_p2 <= dest_p1;
      wb_p2   <= wb_p1;
      dest_p1 <= id_dest;
      if (bubble_p0) begin
        wb_p1        <= 1'b0;
        load_p1      <= 1'b0;
        alu_src1_p1  <= SEL_REG;
        alu_src2_p1  <= SEL_REG;
        store_sel_p1 <= SEL_REG;
      end else begin
        wb_p1        <= id_wb_en;
        load_p1      <= id_mem_read;
        alu_src1_p1  <= alu_src1_p0;
        alu_src2_p1  <= alu_src2_p0;
        store_sel_p1 <= store_sel_p0;
      end
    end
  end

  assign ALU_src1        = alu_src1_p1;
  assign ALU_src2        = alu_src2_p1;
  assign Store_Value_sel = store_sel_p1;
  assign stall           = stall_p0;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_forwarding_hazard_unit
//
// Directed instruction sequences for forwarding_hazard_unit. Each step drives
// one ID-stage instruction and queues the outputs expected during that same
// cycle: selects belong to the previous instruction, stall to the current one.
// A separate monitor pops the queue on every falling edge and compares.
// ---------------------------------------------------------------------------
module tb_forwarding_hazard_unit;

  logic       clk;
  logic       rst;
  logic       freeze;
  logic       flush;
  logic       fwd_en;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_use_src1;
  logic       id_use_src2;
  logic       id_is_imm;
  logic       id_is_store;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_read;
  logic [1:0] ALU_src1;
  logic [1:0] ALU_src2;
  logic [1:0] Store_Value_sel;
  logic       stall;

  forwarding_hazard_unit #(.REG_ADDR_LEN(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .flush           (flush),
    .fwd_en          (fwd_en),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_use_src1     (id_use_src1),
    .id_use_src2     (id_use_src2),
    .id_is_imm       (id_is_imm),
    .id_is_store     (id_is_store),
    .id_dest         (id_dest),
    .id_wb_en        (id_wb_en),
    .id_mem_read     (id_mem_read),
    .ALU_src1        (ALU_src1),
    .ALU_src2        (ALU_src2),
    .Store_Value_sel (Store_Value_sel),
    .stall           (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] ss;
    logic       stl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic g_rst = 1'b0;
  logic g_frz = 1'b0;
  logic g_fl  = 1'b0;
  logic g_fen = 1'b1;

  task automatic step(input string nm, input int s1, input int s2,
                      input logic u1, input logic u2, input logic imm,
                      input logic st, input int d, input logic wb,
                      input logic mr, input int e1, input int e2,
                      input int es, input logic estl);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = g_rst;
    freeze      = g_frz;
    flush       = g_fl;
    fwd_en      = g_fen;
    id_src1     = 5'(s1);
    id_src2     = 5'(s2);
    id_use_src1 = u1;
    id_use_src2 = u2;
    id_is_imm   = imm;
    id_is_store = st;
    id_dest     = 5'(d);
    id_wb_en    = wb;
    id_mem_read = mr;
    e.name = nm;
    e.s1   = 2'(e1);
    e.s2   = 2'(e2);
    e.ss   = 2'(es);
    e.stl  = estl;
    exp_q.push_back(e);
  endtask

  // R-type: rd <- rs op rt
  task automatic alu(input string nm, input int rs, input int rt, input int rd,
                     input int e1, input int e2, input int es, input logic estl);
    step(nm, rs, rt, 1'b1, 1'b1, 1'b0, 1'b0, rd, 1'b1, 1'b0, e1, e2, es, estl);
  endtask

  // lw rd, imm(base)
  task automatic lw(input string nm, input int base, input int rd,
                    input int e1, input int e2, input int es, input logic estl);
    step(nm, base, 0, 1'b1, 1'b0, 1'b1, 1'b0, rd, 1'b1, 1'b1, e1, e2, es, estl);
  endtask

  // sw data, imm(base)
  task automatic sw(input string nm, input int base, input int data,
                    input int e1, input int e2, input int es, input logic estl);
    step(nm, base, data, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, e1, e2, es, estl);
  endtask

  task automatic nop(input string nm, input int e1, input int e2,
                     input int es, input logic estl);
    step(nm, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, e1, e2, es, estl);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({ALU_src1, ALU_src2, Store_Value_sel, stall} !==
            {e.s1, e.s2, e.ss, e.stl}) begin
          errors++;
          $display("FAIL %s: got src1=%0d src2=%0d st_sel=%0d stall=%0b, want src1=%0d src2=%0d st_sel=%0d stall=%0b",
                   e.name, ALU_src1, ALU_src2, Store_Value_sel, stall,
                   e.s1, e.s2, e.ss, e.stl);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; fwd_en = 1'b1;
    id_src1 = '0; id_src2 = '0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
    id_is_imm = 1'b0; id_is_store = 1'b0; id_dest = '0;
    id_wb_en = 1'b0; id_mem_read = 1'b0;
    repeat (2) @(posedge clk);

    g_rst = 1'b1;
    nop("reset_state", 0, 0, 0, 0);
    g_rst = 1'b0;

    // back-to-back ALU
    alu("b2b_add",     1, 2, 3,  0, 0, 0, 0);
    alu("b2b_sub",     3, 5, 4,  0, 0, 0, 0);
    nop("b2b_sub_exe",           1, 0, 0, 0);
    nop("b2b_drain",             0, 0, 0, 0);

    // distance 2 with younger producer in the middle
    alu("d2y_add",     1, 2, 3,  0, 0, 0, 0);
    alu("d2y_or",      1, 2, 3,  0, 0, 0, 0);
    alu("d2y_and",     3, 3, 6,  0, 0, 0, 0);
    nop("d2y_and_exe",           1, 1, 0, 0);

    // distance 2 with an unrelated middle instruction
    alu("d2_add",      1, 2, 3,  0, 0, 0, 0);
    alu("d2_xor",      9, 10, 8, 0, 0, 0, 0);
    alu("d2_and",      3, 3, 6,  0, 0, 0, 0);
    nop("d2_and_exe",            2, 2, 0, 0);

    // load-use: one stall, one bubble, then forward from WB
    lw ("lu_lw",       1, 2,     0, 0, 0, 0);
    alu("lu_add_stall",2, 2, 4,  0, 0, 0, 1);
    alu("lu_add_retry",2, 2, 4,  0, 0, 0, 0);
    nop("lu_add_exe",            2, 2, 0, 0);

    // store data forwarded, ALU operand 2 is the immediate
    alu("st_add",      1, 2, 7,  0, 0, 0, 0);
    sw ("st_sw",       1, 7,     0, 0, 0, 0);
    nop("st_sw_exe",             0, 0, 1, 0);

    // r0 never forwards, never stalls
    alu("r0_wr",       1, 2, 0,  0, 0, 0, 0);
    alu("r0_rd",       0, 0, 5,  0, 0, 0, 0);
    nop("r0_rd_exe",             0, 0, 0, 0);
    lw ("r0_lw",       1, 0,     0, 0, 0, 0);
    alu("r0_lu",       0, 0, 4,  0, 0, 0, 0);
    nop("r0_lu_exe",             0, 0, 0, 0);

    // forwarding disabled: distance-1 RAW stalls two cycles
    g_fen = 1'b0;
    alu("nf_add",      1, 2, 3,  0, 0, 0, 0);
    alu("nf_sub_st1",  3, 5, 4,  0, 0, 0, 1);
    alu("nf_sub_st2",  3, 5, 4,  0, 0, 0, 1);
    alu("nf_sub_go",   3, 5, 4,  0, 0, 0, 0);
    nop("nf_sub_exe",            0, 0, 0, 0);
    g_fen = 1'b1;
    nop("nf_drain",              0, 0, 0, 0);

    // flush coincident with load-use
    lw ("fl_lw",       1, 2,     0, 0, 0, 0);
    g_fl = 1'b1;
    alu("fl_add",      2, 2, 4,  0, 0, 0, 0);
    g_fl = 1'b0;
    nop("fl_bubble",             0, 0, 0, 0);

    // reset clears registered selects and MEM tracking
    alu("rs_add",      1, 2, 3,  0, 0, 0, 0);
    alu("rs_sub",      3, 5, 4,  0, 0, 0, 0);
    g_rst = 1'b1;
    nop("rs_assert",             1, 0, 0, 0);
    g_rst = 1'b0;
    alu("rs_after",    3, 4, 6,  0, 0, 0, 0);
    nop("rs_after_exe",          0, 0, 0, 0);

    // reset mid-stall
    lw ("rm_lw",       1, 2,     0, 0, 0, 0);
    g_rst = 1'b1;
    alu("rm_add_st",   2, 2, 4,  0, 0, 0, 1);
    g_rst = 1'b0;
    alu("rm_add",      2, 2, 4,  0, 0, 0, 0);
    nop("rm_add_exe",            0, 0, 0, 0);

    // freeze holds selects
    alu("fz_add",      1, 2, 3,  0, 0, 0, 0);
    alu("fz_sub",      3, 5, 4,  0, 0, 0, 0);
    g_frz = 1'b1;
    nop("fz_hold1",              1, 0, 0, 0);
    nop("fz_hold2",              1, 0, 0, 0);
    g_frz = 1'b0;
    nop("fz_release",            1, 0, 0, 0);
    nop("fz_drain",              0, 0, 0, 0);

    // freeze masks a load-use stall, which reappears afterwards
    lw ("fzl_lw",      1, 2,     0, 0, 0, 0);
    g_frz = 1'b1;
    alu("fzl_frozen",  2, 2, 4,  0, 0, 0, 0);
    g_frz = 1'b0;
    alu("fzl_stall",   2, 2, 4,  0, 0, 0, 1);
    alu("fzl_retry",   2, 2, 4,  0, 0, 0, 0);
    nop("fzl_exe",               2, 2, 0, 0);
    nop("fzl_drain",             0, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
